// File: rtl/nibble_ser_tx.sv
// -----------------------------------------------------------------------------
// nibble_ser_tx
//   Serial transmitter for 4-bit pattern words. A nibble {A,B,C,D} is taken
//   over a valid/ready handshake and shifted out MSB-first (A first) on a
//   single-bit line. A start-of-frame marker accompanies bit A. A pattern flag
//   accompanies bit D when the nibble is the detection pattern 0110. GAP idle
//   cycles can optionally follow each nibble.
//
// Parameters
//   GAP        idle cycles inserted after each nibble (0..15)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   in_data holds a word to send
//   in_data    word to send: bit3=A, bit2=B, bit1=C, bit0=D
//   in_ready   word can be accepted this cycle (combinational from state)
//   ser_out    serial data bit (registered, 0 when ser_valid is low)
//   ser_valid  ser_out carries a data bit (registered)
//   sof        high on the bit-A cycle of each nibble (registered)
//   pat_tx     high on the bit-D cycle of a 0110 nibble (registered)
//   busy       high while shifting or in the inter-nibble gap (registered)
// -----------------------------------------------------------------------------
module nibble_ser_tx #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       sof,
  output logic       pat_tx,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic       GAP_ZERO = (GAP == 0);
  localparam logic [3:0] GAP_M1   = GAP_ZERO ? 4'd0 : 4'(GAP - 1);
  localparam logic [3:0] PATTERN  = 4'b0110;

  state_t     state_q, state_d;
  logic [3:0] shreg_q, shreg_d;
  logic [1:0] bitcnt_q, bitcnt_d;
  logic [3:0] gapcnt_q, gapcnt_d;
  logic [3:0] word_q, word_d;

  logic ser_out_q, ser_out_d;
  logic ser_valid_q, ser_valid_d;
  logic sof_q, sof_d;
  logic pat_tx_q, pat_tx_d;
  logic busy_q, busy_d;

  logic accept;

  // Ready in IDLE, and on the last bit of a nibble when no gap follows, so a
  // back-to-back stream has no idle cycle between nibbles.
  assign in_ready = (state_q == S_IDLE) |
                    ((state_q == S_SHIFT) & (bitcnt_q == 2'd3) & GAP_ZERO);
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    word_d   = word_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_SHIFT;
          shreg_d  = in_data;
          word_d   = in_data;
          bitcnt_d = 2'd0;
        end
      end

      S_SHIFT: begin
        // Shift every SHIFT cycle; after bit D the register has drained to 0,
        // so nothing stale survives into the gap or idle.
        shreg_d  = {shreg_q[2:0], 1'b0};
        bitcnt_d = bitcnt_q + 2'd1;
        if (bitcnt_q == 2'd3) begin
          if (accept) begin
            shreg_d  = in_data;
            word_d   = in_data;
            bitcnt_d = 2'd0;
          end else if (!GAP_ZERO) begin
            state_d  = S_GAP;
            gapcnt_d = GAP_M1;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (gapcnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are computed from the next state so that, once registered, they
    // line up with the cycle the state register holds that state.
    ser_valid_d = (state_d == S_SHIFT);
    ser_out_d   = ser_valid_d & shreg_d[3];
    sof_d       = ser_valid_d & (bitcnt_d == 2'd0);
    pat_tx_d    = ser_valid_d & (bitcnt_d == 2'd3) & (word_d == PATTERN);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: all state and output flops sit on the asynchronous reset so a reset
  // mid-frame silences the line immediately, without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= 4'd0;
      bitcnt_q    <= 2'd0;
      gapcnt_q    <= 4'd0;
      word_q      <= 4'd0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      pat_tx_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      gapcnt_q    <= gapcnt_d;
      word_q      <= word_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      sof_q       <= sof_d;
      pat_tx_q    <= pat_tx_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign sof       = sof_q;
  assign pat_tx    = pat_tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_ser_tx.sv
// -----------------------------------------------------------------------------
// tb_nibble_ser_tx
//   Three instances of nibble_ser_tx (GAP = 0, 3, 2), each with its own
//   driver and a reference model plus monitor. The model decides from the
//   handshake rules when a word is taken and queues the four expected bit
//   cycles (cycle number, data, sof, pat). The monitor compares every cycle
//   against the queue head or the idle expectation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nibble_ser_tx;

  typedef struct {
    int   cyc;
    logic b;
    logic s;
    logic p;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Compared vector layout: {ser_valid, ser_out, sof, pat_tx, busy, in_ready}
  task automatic check(input string name, input logic [5:0] act,
                       input logic [5:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b (vld,bit,sof,pat,busy,rdy)",
               name, act, exp);
    else
      n_pass++;
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int G = (gi == 0) ? 0 : (gi == 1) ? 3 : 2;

    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready, ser_out, ser_valid, sof, pat_tx, busy;
    bit         done = 1'b0;

    int   edge_n   = 0;
    int   next_ok  = 0;   // first edge at which a word may be taken
    int   busy_end = 0;   // first cycle index no longer busy
    int   acc_cnt  = 0;   // words taken so far
    exp_t q[$];

    nibble_ser_tx #(.GAP(G)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .ser_out  (ser_out),
      .ser_valid(ser_valid),
      .sof      (sof),
      .pat_tx   (pat_tx),
      .busy     (busy)
    );

    // Reference model (at each rising edge) and monitor (at each falling edge).
    initial begin : model_mon
      exp_t       e;
      logic [5:0] expv;
      logic       bexp, rexp;
      forever begin
        @(posedge clk);
        edge_n++;
        if (rst) begin
          q.delete();
          next_ok  = 0;
          busy_end = 0;
        end else if (in_valid && edge_n >= next_ok) begin
          for (int j = 0; j < 4; j++) begin
            e.cyc = edge_n + j;
            e.b   = in_data[3-j];
            e.s   = (j == 0);
            e.p   = (j == 3) && (in_data == 4'b0110);
            q.push_back(e);
          end
          next_ok  = edge_n + ((G == 0) ? 4 : 5 + G);
          busy_end = edge_n + 4 + G;
          acc_cnt++;
        end

        @(negedge clk);
        if (rst) begin
          q.delete();
          next_ok  = 0;
          busy_end = 0;
          expv     = 6'b000001;
        end else begin
          bexp = (edge_n < busy_end);
          rexp = (edge_n + 1 >= next_ok);
          if (q.size() > 0 && q[0].cyc == edge_n) begin
            e    = q.pop_front();
            expv = {1'b1, e.b, e.s, e.p, bexp, rexp};
          end else begin
            expv = {4'b0000, bexp, rexp};
          end
        end
        check($sformatf("g%0d_cyc%0d", G, edge_n),
              {ser_valid, ser_out, sof, pat_tx, busy, in_ready}, expv);
      end
    end

    // Present w (called at a falling edge) and hold it until the model takes
    // it; returns at the falling edge of the bit-A cycle.
    task automatic send(input logic [3:0] w, input bit drop_after);
      int a0;
      int t;
      a0       = acc_cnt;
      in_valid = 1'b1;
      in_data  = w;
      t        = 0;
      do begin
        @(negedge clk);
        t++;
      end while (acc_cnt == a0 && t < 40);
      if (drop_after) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);   // must not disturb the word in flight
      end
    endtask

    task automatic random_words(input int n);
      bit drop;
      for (int k = 0; k < n; k++) begin
        drop = 1'($urandom_range(0, 1));
        send(4'($urandom), drop);
        if (drop) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b0;
    endtask

    initial begin : driver
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      if (G == 0) begin
        // Single detection pattern
        send(4'b0110, 1'b1);
        repeat (6) @(negedge clk);
        // Back-to-back stream with in_valid held
        send(4'b0110, 1'b0);
        send(4'b1111, 1'b0);
        send(4'b0000, 1'b1);
        repeat (6) @(negedge clk);
        // Every nibble value, back-to-back
        for (int w = 0; w < 16; w++) send(4'(w), w == 15);
        repeat (6) @(negedge clk);
        // Reset in the bit-B cycle, then a clean word right after release
        send(4'b0110, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("g0_rst_mid_nibble",
                 {ser_valid, ser_out, sof, pat_tx, busy, in_ready}, 6'b000001);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(4'b1001, 1'b1);
        repeat (6) @(negedge clk);
      end else if (G == 3) begin
        send(4'b1010, 1'b0);
        send(4'b0101, 1'b1);
        repeat (10) @(negedge clk);
      end else begin
        // in_valid pulsed while busy is ignored; in_data churn has no effect
        send(4'b1100, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0110;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          in_data = 4'($urandom);
        end
        repeat (8) @(negedge clk);
      end

      random_words(50);
      repeat (12) @(negedge clk);
      done = 1'b1;
    end
  end

  initial begin
    wait (g[0].done && g[1].done && g[2].done);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required all drivers done");
    $fatal(1);
  end

endmodule

// File: doc/nibble_ser_tx.md
# nibble_ser_tx

Serial transmitter for 4-bit pattern words. It accepts a parallel nibble {A,B,C,D} over a valid/ready handshake and shifts it out MSB-first (A first) on a single-bit line, with a start-of-frame marker. It also flags when the word being sent is the detection pattern 0110 (A=0, B=1, C=1, D=0). It feeds serial links whose far end reassembles nibbles for the pattern decoder.

## Interface
- `GAP`, default 0: idle cycles inserted after each nibble, range 0..15.
- `clk  input  1`: clock; all state changes on the rising edge.
- `rst  input  1`: asynchronous reset, active-high.
- `in_valid  input  1`: `in_data` holds a word to send.
- `in_data  input  4`: word; bit3=A, bit2=B, bit1=C, bit0=D.
- `in_ready  output  1`: block accepts a word this cycle; combinational from state.
- `ser_out  output  1`: serial data bit, registered.
- `ser_valid  output  1`: `ser_out` carries a data bit, registered.
- `sof  output  1`: high on the bit-A cycle of each nibble, registered.
- `pat_tx  output  1`: high on the bit-D cycle when the nibble sent was 4'b0110, registered.
- `busy  output  1`: high in SHIFT or GAP, registered.

## Operation
- States: IDLE, SHIFT, GAP. Internal regs: `shreg[3:0]`, `bitcnt[1:0]`, `gapcnt[3:0]`, `word[3:0]`.
- Accept = `in_valid & in_ready` at a rising edge. On accept, load `shreg` and `word` with `in_data`, set `bitcnt` = 0, and go to SHIFT.
- `in_ready` = (state==IDLE) | (state==SHIFT & bitcnt==3 & GAP==0).
- SHIFT: `ser_out` = `shreg[3]`, and `shreg` shifts left by one each cycle. `bitcnt` increments 0→3 and wraps to 0.
- At the end of the bitcnt==3 cycle:
  - accept pending (GAP=0 only): reload and stay in SHIFT, giving a back-to-back stream.
  - otherwise, if GAP>0: go to GAP with `gapcnt` = GAP−1.
  - otherwise: go to IDLE.
- GAP: `ser_valid` = 0 and `ser_out` = 0. `gapcnt` decrements. Exit to IDLE when `gapcnt` = 0.
- Outputs are registered from next-state logic, so they are valid in the cycle the state is in SHIFT.
- `sof` = 1 when bitcnt==0 in SHIFT.
- `pat_tx` = 1 when bitcnt==3 in SHIFT and `word` == 4'b0110.
- `ser_out` is 0 whenever `ser_valid` = 0.
- `in_data` is sampled only on accept. Changes to it at other times have no effect.
- `in_valid` is ignored when `in_ready` = 0. The upstream holds the word until it is accepted.

## Timing
- Reset (async, immediate):
  - state = IDLE; `ser_out`, `ser_valid`, `sof`, `pat_tx`, `busy` = 0.
  - internal regs = 0; `in_ready` = 1.
  - No accept occurs while `rst` is high.
- Reset mid-nibble or mid-gap: the frame is abandoned with outputs 0 immediately. After release the block is in IDLE with no residual bits. The first edge after release can accept a word.
- Latency: accept at edge k gives `sof` = 1 and bit A in cycle k+1. Bits B, C, D follow in cycles k+2, k+3, k+4.
- Throughput:
  - GAP=0: one nibble per 4 cycles, `ser_valid` continuously high.
  - GAP=g>0: one nibble per 4+g+1 cycles (4 bits, g gap cycles, 1 IDLE accept cycle).
- `busy` tracks `ser_valid` plus the GAP cycles. It is 0 in IDLE.
- Simultaneous events:
  - accept on the last bit (GAP=0): the next `sof` comes directly after bit D, with no idle cycle.
  - `in_valid` held high continuously: words are taken on every `in_ready`, with none dropped or duplicated.

## Test plan
- Reset, then send 0110 with GAP=0: `ser_out` = 0,1,1,0 in cycles k+1..k+4. `sof` = 1 only at k+1, `pat_tx` = 1 only at k+4, and `ser_valid` drops at k+5.
- Back-to-back 0110, 1111, 0000 with `in_valid` held, GAP=0: 12 contiguous valid bits 011011110000. `sof` at 1st, 5th, 9th. `pat_tx` only at 4th bit.
- GAP=3, send 1010 then 0101: bits 1,0,1,0, then 3 cycles with `ser_valid` = 0 and `busy` = 1, then 1 IDLE cycle, then 0,1,0,1. Nibble period is 8 cycles.
- Exhaustive 0000..1111 (GAP=0): each nibble serialises correctly. `pat_tx` asserts exactly once, for 0110.
- Assert `rst` during the bit-B cycle of 0110: all outputs 0 in the same cycle. After release `in_ready` = 1. A new word 1001 is sent cleanly with no leftover bits.
- `in_valid` pulsed while `busy` (GAP=2): pulse ignored, no extra nibble sent. `in_data` changing during SHIFT does not alter `ser_out`.
